byte_pack_stage: RTL

- Upstream feeder for the byte-wide port-test modules.
- Collects a stream of 8-bit bytes under a valid/ready handshake and packs them little-endian into 32-bit words; a last flag flushes a partial word early.
- Buffers packed words in a small FIFO and presents them downstream under a valid/ready handshake with a byte-lane mask.

---
 rtl/byte_pack_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/byte_pack_stage.sv
// Packs a valid/ready byte stream little-endian into 32-bit words and queues them in a small FIFO.
// Optional even-parity checking on input bytes is enabled by defining BYTE_PACK_STAGE_PARITY_EN.
`timescale 1ns/1ps

module byte_pack_stage #(
   parameter int DEPTH = 2,
   parameter int LANES = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [7:0]  in_data_i,
   input  logic        in_last_i,
   input  logic        in_parity_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_data_o,
   output logic [3:0]  out_bmask_o,
   output logic        out_last_o,
   output logic [3:0]  out_count_o,
   output logic        perr_o
);

   // state | meaning
   // FILL0 | next accepted byte goes to lane 0 (bits 7:0)
   // FILL1 | next accepted byte goes to lane 1 (bits 15:8)
   // FILL2 | next accepted byte goes to lane 2 (bits 23:16)
   // FILL3 | next accepted byte goes to lane 3 and closes the word
   typedef enum logic [1:0] {FILL0, FILL1, FILL2, FILL3} state_t;

   localparam int PW = $clog2(DEPTH);

   if (LANES != 4 || !(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_param
      $error("byte_pack_stage: LANES must be 4 and DEPTH must be 2, 4 or 8");
   end

   state_t            state_q, state_d, state_nxt;
   logic [31:0]       acc_q, acc_d, acc_new;
   logic [3:0]        mask_q, mask_d, mask_new;
   logic [31:0]       mem_data_q [DEPTH];
   logic [31:0]       mem_data_d [DEPTH];
   logic [3:0]        mem_mask_q [DEPTH];
   logic [3:0]        mem_mask_d [DEPTH];
   logic              mem_last_q [DEPTH];
   logic              mem_last_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [3:0]        count_q, count_d;
   logic              accept, close, pop;

   assign in_ready_o  = (count_q != 4'(DEPTH));
   assign out_valid_o = (count_q != 4'd0);
   assign out_count_o = count_q;
   assign out_data_o  = out_valid_o ? mem_data_q[rd_ptr_q] : 32'd0;
   assign out_bmask_o = out_valid_o ? mem_mask_q[rd_ptr_q] : 4'd0;
   assign out_last_o  = out_valid_o ? mem_last_q[rd_ptr_q] : 1'b0;

   assign accept = in_valid_i && in_ready_o;
   assign pop    = out_valid_o && out_ready_i;
   assign close  = accept && (state_q == FILL3 || in_last_i);

   always_comb begin
      acc_new   = acc_q;
      mask_new  = mask_q;
      state_nxt = FILL0;
      case (state_q)
         FILL0: begin acc_new[7:0]   = in_data_i; mask_new[0] = 1'b1; state_nxt = FILL1; end
         FILL1: begin acc_new[15:8]  = in_data_i; mask_new[1] = 1'b1; state_nxt = FILL2; end
         FILL2: begin acc_new[23:16] = in_data_i; mask_new[2] = 1'b1; state_nxt = FILL3; end
         FILL3: begin acc_new[31:24] = in_data_i; mask_new[3] = 1'b1; state_nxt = FILL0; end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mask_d     = mask_q;
      mem_data_d = mem_data_q;
      mem_mask_d = mem_mask_q;
      mem_last_d = mem_last_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q + 4'(close) - 4'(pop);
      if (accept) begin
         if (close) begin
            state_d = FILL0;
            acc_d   = 32'd0;
            mask_d  = 4'd0;
         end else begin
            state_d = state_nxt;
            acc_d   = acc_new;
            mask_d  = mask_new;
         end
      end
      // close implies accept, which implies the FIFO has room
      if (close) begin
         mem_data_d[wr_ptr_q] = acc_new;
         mem_mask_d[wr_ptr_q] = mask_new;
         mem_last_d[wr_ptr_q] = in_last_i;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= FILL0;
         acc_q      <= 32'd0;
         mask_q     <= 4'd0;
         mem_data_q <= '{default: 32'd0};
         mem_mask_q <= '{default: 4'd0};
         mem_last_q <= '{default: 1'b0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= 4'd0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         mask_q     <= mask_d;
         mem_data_q <= mem_data_d;
         mem_mask_q <= mem_mask_d;
         mem_last_q <= mem_last_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

`ifdef BYTE_PACK_STAGE_PARITY_EN
   logic perr_q, perr_d;

   // Sticky: a bad byte is still packed, only the flag records it
   always_comb begin
      perr_d = perr_q;
      if (accept && ((^in_data_i) != in_parity_i)) begin
         perr_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign perr_o = perr_q;
`else
   logic unused_parity;
   assign unused_parity = in_parity_i;
   assign perr_o        = 1'b0;
`endif

endmodule
